// File: rtl/mac62_pkg.sv
// Shared widths, the sign-magnitude result type and its conversion helper
// for the 62-term sign-magnitude MAC.
package mac62_pkg;

  localparam int unsigned N_TERMS     = 62;
  localparam int unsigned DW          = 8;                  // element: sign + 7-bit magnitude
  localparam int unsigned MAG_W       = DW - 1;
  localparam int unsigned PMAG_W      = 2 * MAG_W;          // product magnitude, max 16129
  localparam int unsigned PROD_W      = PMAG_W + 1;         // signed product
  localparam int unsigned ACC_W       = 21;                 // |sum| <= 999998 < 2^20
  localparam int unsigned OW          = 21;
  localparam int unsigned OMAG_W      = OW - 1;
  localparam int unsigned BUS_W       = N_TERMS * DW;
  localparam int unsigned TREE_LEAVES = 64;                 // N_TERMS padded to a power of two

  // Sign-magnitude result word.
  typedef struct packed {
    logic              sign;
    logic [OMAG_W-1:0] mag;
  } sm_out_t;

  // Two's-complement sum to sign-magnitude; zero always comes out as +0.
  function automatic sm_out_t to_sign_mag(input logic signed [ACC_W-1:0] s);
    sm_out_t r;
    r.sign = s[ACC_W-1];
    if (s[ACC_W-1]) begin
      r.mag = OMAG_W'(-s);
    end else begin
      r.mag = s[OMAG_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac62_if.sv
// Operand/result bundle for mac62.
//   in_valid  : a/w carry a valid operand set this cycle
//   a, w      : 62 packed sign-magnitude elements, element i at [8i+7:8i]
//   out_valid : out carries a valid result this cycle
//   out       : 21-bit sign-magnitude sum
interface mac62_if;
  import mac62_pkg::*;

  logic             in_valid;
  logic [BUS_W-1:0] a;
  logic [BUS_W-1:0] w;
  logic             out_valid;
  logic [OW-1:0]    out;

  modport master (output in_valid, output a, output w, input out_valid, input out);
  modport slave  (input in_valid, input a, input w, output out_valid, output out);

endinterface

// File: rtl/mac62_smul.sv
// 8b x 8b sign-magnitude multiply to a 15-bit two's-complement product.
//   a, w : sign-magnitude operands (bit 7 = sign)
//   p_c  : signed product, combinational; a zero magnitude always gives 0
module mac62_smul
  import mac62_pkg::*;
(
  input  logic [DW-1:0]            a,
  input  logic [DW-1:0]            w,
  output logic signed [PROD_W-1:0] p_c
);

  logic [PMAG_W-1:0] mag;

  // Negating a zero magnitude yields zero, so "-0" needs no special case.
  always_comb begin
    mag = PMAG_W'(a[MAG_W-1:0]) * PMAG_W'(w[MAG_W-1:0]);
    p_c = {1'b0, mag};
    if (a[DW-1] ^ w[DW-1]) begin
      p_c = -{1'b0, mag};
    end
  end

endmodule

// File: rtl/mac62.sv
// 62-term sign-magnitude multiply-accumulate, 3-stage pipeline:
//   S1 registers the 62 signed products, S2 the adder-tree sum,
//   S3 the sign-magnitude result. One operand set per clock, no stall.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : mac62_if slave (in_valid/a/w in, out_valid/out out)
module mac62
  import mac62_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  mac62_if.slave  bus
);

  logic signed [PROD_W-1:0] prod_c [N_TERMS];
  logic signed [PROD_W-1:0] prod_q [N_TERMS];
  logic                     valid_s1_q;

  logic signed [ACC_W-1:0]  leaf_c [TREE_LEAVES];
  logic signed [ACC_W-1:0]  lvl1_c [32];
  logic signed [ACC_W-1:0]  lvl2_c [16];
  logic signed [ACC_W-1:0]  lvl3_c [8];
  logic signed [ACC_W-1:0]  lvl4_c [4];
  logic signed [ACC_W-1:0]  lvl5_c [2];
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     valid_s2_q;

  // Element multipliers.
  for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_mul
    mac62_smul u_smul (
      .a   (bus.a[gi*DW +: DW]),
      .w   (bus.w[gi*DW +: DW]),
      .p_c (prod_c[gi])
    );
  end

  // S1: product registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TERMS; i++) begin
        prod_q[i] <= '0;
      end
      valid_s1_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_TERMS; i++) begin
        prod_q[i] <= prod_c[i];
      end
      valid_s1_q <= bus.in_valid;
    end
  end

  // Balanced adder tree; leaves sign-extended to the accumulator width and
  // padded with zeros up to 64.
  always_comb begin
    for (int j = 0; j < TREE_LEAVES; j++) begin
      leaf_c[j] = '0;
    end
    for (int j = 0; j < N_TERMS; j++) begin
      leaf_c[j] = {{(ACC_W-PROD_W){prod_q[j][PROD_W-1]}}, prod_q[j]};
    end
    for (int j = 0; j < 32; j++) lvl1_c[j] = leaf_c[2*j] + leaf_c[2*j+1];
    for (int j = 0; j < 16; j++) lvl2_c[j] = lvl1_c[2*j] + lvl1_c[2*j+1];
    for (int j = 0; j < 8;  j++) lvl3_c[j] = lvl2_c[2*j] + lvl2_c[2*j+1];
    for (int j = 0; j < 4;  j++) lvl4_c[j] = lvl3_c[2*j] + lvl3_c[2*j+1];
    for (int j = 0; j < 2;  j++) lvl5_c[j] = lvl4_c[2*j] + lvl4_c[2*j+1];
    sum_c = lvl5_c[0] + lvl5_c[1];
  end

  // S2: sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q      <= '0;
      valid_s2_q <= 1'b0;
    end else begin
      sum_q      <= sum_c;
      valid_s2_q <= valid_s1_q;
    end
  end

  // S3: result register; out only moves on a valid result and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= valid_s2_q;
      if (valid_s2_q) begin
        bus.out <= to_sign_mag(sum_q);
      end
    end
  end

endmodule

// File: tb/tb_mac62.sv
// Directed and random checks of mac62 against an integer reference model.
module tb_mac62;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // reference pipeline state
  logic        m_v1, m_v2, m_ov;
  logic [20:0] m_r1, m_r2, m_out;

  logic [495:0] va, vw;

  mac62_if bus ();

  mac62 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] ref_mac(input logic [495:0] a, input logic [495:0] w);
    int s;
    int p;
    s = 0;
    for (int i = 0; i < 62; i++) begin
      p = int'(a[8*i +: 7]) * int'(w[8*i +: 7]);
      if (a[8*i+7] ^ w[8*i+7]) s = s - p;
      else                     s = s + p;
    end
    if (s < 0) return {1'b1, 20'(-s)};
    return {1'b0, 20'(s)};
  endfunction

  task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [495:0] a, input logic [495:0] w);
    bus.in_valid = v;
    bus.a        = a;
    bus.w        = w;
  endtask

  task automatic clear_model();
    m_v1 = 1'b0; m_v2 = 1'b0; m_ov = 1'b0;
    m_r1 = '0;   m_r2 = '0;   m_out = '0;
  endtask

  // One clock: advance the reference pipeline with the pre-edge inputs,
  // then compare both outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      if (m_v2) m_out = m_r2;
      m_ov = m_v2;
      m_v2 = m_v1;
      m_r2 = m_r1;
      m_v1 = bus.in_valid;
      m_r1 = ref_mac(bus.a, bus.w);
    end
    #1;
    chk("out_valid", 21'(bus.out_valid), 21'(m_ov));
    chk("out", bus.out, m_out);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_model();
    rst = 1'b1;
    drive(1'b0, '0, '0);

    // reset state
    tick();
    tick();
    chk("rst_out", bus.out, 21'h000000);
    chk("rst_valid", 21'(bus.out_valid), 21'h0);
    rst = 1'b0;

    // mixed: -254 + 309 + 372 - 500 = -73
    va = '0; vw = '0;
    va[31:0] = {8'hFF, 8'hE7, 8'h5D, 8'h64};
    vw[31:0] = {8'h02, 8'h83, 8'h04, 8'h85};
    drive(1'b1, va, vw);
    tick();
    drive(1'b0, '0, '0);
    tick();
    chk("mixed_early_valid", 21'(bus.out_valid), 21'h0);
    tick();
    chk("mixed", bus.out, 21'h100049);
    chk("mixed_valid", 21'(bus.out_valid), 21'h1);
    tick();
    chk("mixed_hold", bus.out, 21'h100049);
    chk("mixed_hold_valid", 21'(bus.out_valid), 21'h0);

    // max positive
    drive(1'b1, {62{8'h7F}}, {62{8'h7F}});
    tick();
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("max_pos", bus.out, 21'h0F423E);

    // max negative
    drive(1'b1, {62{8'hFF}}, {62{8'h7F}});
    tick();
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("max_neg", bus.out, 21'h1F423E);

    // all zero
    drive(1'b1, '0, '0);
    tick();
    drive(1'b0, '0, '0);
    tick(); tick();
    chk("zero", bus.out, 21'h000000);
    chk("zero_valid", 21'(bus.out_valid), 21'h1);

    // negative zeros, after a nonzero result so the change is visible
    drive(1'b1, {62{8'h7F}}, {62{8'h7F}});
    tick();
    drive(1'b1, {62{8'h80}}, {62{8'h80}});
    tick();
    drive(1'b0, '0, '0);
    tick();
    chk("pre_negzero", bus.out, 21'h0F423E);
    tick();
    chk("negzero", bus.out, 21'h000000);

    // throughput: four back-to-back sets
    va = '0; vw = '0; va[7:0] = 8'h01; vw[7:0] = 8'h01;          // +1
    drive(1'b1, va, vw);
    tick();
    va = '0; vw = '0; va[7:0] = 8'h85; vw[7:0] = 8'h07;          // -35
    drive(1'b1, va, vw);
    tick();
    drive(1'b1, {62{8'h01}}, {62{8'h81}});                       // -62
    tick();
    chk("tp0", bus.out, 21'h000001);
    chk("tp0_valid", 21'(bus.out_valid), 21'h1);
    drive(1'b1, {62{8'hFF}}, {62{8'h7F}});                       // -999998
    tick();
    chk("tp1", bus.out, 21'h100023);
    chk("tp1_valid", 21'(bus.out_valid), 21'h1);
    drive(1'b0, '0, '0);
    tick();
    chk("tp2", bus.out, 21'h10003E);
    chk("tp2_valid", 21'(bus.out_valid), 21'h1);
    tick();
    chk("tp3", bus.out, 21'h1F423E);
    chk("tp3_valid", 21'(bus.out_valid), 21'h1);
    tick();
    chk("tp_end_valid", 21'(bus.out_valid), 21'h0);

    // reset one cycle after in_valid
    drive(1'b1, {62{8'h7F}}, {62{8'h7F}});
    tick();
    drive(1'b0, '0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_out", bus.out, 21'h000000);
    chk("midrst_valid", 21'(bus.out_valid), 21'h0);
    clear_model();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("post_rst_out", bus.out, 21'h000000);

    // random operand sets with random in_valid
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 62; i++) begin
        va[8*i +: 8] = 8'($urandom);
        vw[8*i +: 8] = 8'($urandom);
        if ($urandom_range(0, 7) == 0) va[8*i +: 7] = 7'd0;
        if ($urandom_range(0, 7) == 0) vw[8*i +: 7] = 7'd0;
      end
      drive(1'($urandom_range(0, 3) != 0), va, vw);
      tick();
    end
    drive(1'b0, '0, '0);
    for (int k = 0; k < 4; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
